// File: rtl/reg_readback_if.sv
// rtl/reg_readback_if.sv - byte stream carrying the register readback frame
interface reg_readback_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_readback.sv
// rtl/reg_readback.sv - snapshots the five config registers and streams them as a checked byte frame
module reg_readback #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           RnotW,
  input  logic           start,
  input  logic [7:0]     init_re,
  input  logic [7:0]     init_im,
  input  logic [7:0]     re_coeff,
  input  logic [7:0]     im_coeff,
  input  logic [7:0]     power,
  reg_readback_if.master stream,
  output logic           busy,
  output logic           done
);

  // Index of the byte that closes the frame: checksum slot or power slot.
  localparam logic [2:0] LAST_INDEX = CHECKSUM_EN ? 3'd6 : 3'd5;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state;
  logic [2:0] index;
  logic [7:0] snap_init_re;
  logic [7:0] snap_init_im;
  logic [7:0] snap_re_coeff;
  logic [7:0] snap_im_coeff;
  logic [7:0] snap_power;
  logic [7:0] checksum;
  logic [7:0] data_q;
  logic       valid_q;
  logic       last_q;

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;

  // Frame byte at a given position, always taken from the snapshot.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = snap_init_re;
      3'd2:    b = snap_init_im;
      3'd3:    b = snap_re_coeff;
      3'd4:    b = snap_im_coeff;
      3'd5:    b = snap_power;
      3'd6:    b = checksum;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Frame FSM: capture on an accepted request, advance one byte per handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      index         <= 3'd0;
      snap_init_re  <= 8'h00;
      snap_init_im  <= 8'h00;
      snap_re_coeff <= 8'h00;
      snap_im_coeff <= 8'h00;
      snap_power    <= 8'h00;
      checksum      <= 8'h00;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && RnotW) begin
            snap_init_re  <= init_re;
            snap_init_im  <= init_im;
            snap_re_coeff <= re_coeff;
            snap_im_coeff <= im_coeff;
            snap_power    <= power;
            checksum      <= init_re ^ init_im ^ re_coeff ^ im_coeff ^ power;
            index         <= 3'd0;
            state         <= SEND;
            busy          <= 1'b1;
            valid_q       <= 1'b1;
            data_q        <= HEADER;
            last_q        <= 1'b0;
          end
        end
        SEND: begin
          if (valid_q && stream.out_ready) begin
            if (index == LAST_INDEX) begin
              // Final byte accepted; out_data keeps it as the idle value.
              state   <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              index  <= index + 3'd1;
              data_q <= frame_byte(index + 3'd1);
              last_q <= ((index + 3'd1) == LAST_INDEX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_readback.sv
// tb/tb_reg_readback.sv - randomized and directed checks of reg_readback against a frame-level model
module tb_reg_readback;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rnotw = 1'b0;
  logic       start = 1'b0;
  logic [7:0] init_re = 8'h00, init_im = 8'h00, re_coeff = 8'h00, im_coeff = 8'h00, power = 8'h00;
  logic       rdy [2];
  logic       busy0, busy1, done0, done1;

  reg_readback_if bus0 ();
  reg_readback_if bus1 ();

  assign bus0.out_ready = rdy[0];
  assign bus1.out_ready = rdy[1];

  reg_readback #(.HEADER(8'hA5), .CHECKSUM_EN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .RnotW(rnotw), .start(start),
    .init_re(init_re), .init_im(init_im), .re_coeff(re_coeff), .im_coeff(im_coeff), .power(power),
    .stream(bus0.master), .busy(busy0), .done(done0)
  );

  reg_readback #(.HEADER(8'hA5), .CHECKSUM_EN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .RnotW(rnotw), .start(start),
    .init_re(init_re), .init_im(init_im), .re_coeff(re_coeff), .im_coeff(im_coeff), .power(power),
    .stream(bus1.master), .busy(busy1), .done(done1)
  );

  logic [7:0] d_data [2];
  logic       d_valid [2];
  logic       d_last [2];
  logic       d_busy [2];
  logic       d_done [2];
  assign d_data[0] = bus0.out_data;   assign d_data[1] = bus1.out_data;
  assign d_valid[0] = bus0.out_valid; assign d_valid[1] = bus1.out_valid;
  assign d_last[0] = bus0.out_last;   assign d_last[1] = bus1.out_last;
  assign d_busy[0] = busy0;           assign d_busy[1] = busy1;
  assign d_done[0] = done0;           assign d_done[1] = done1;

  int checks = 0;
  int failures = 0;

  // Model state: the frame as a byte list plus a read position.
  bit         active [2];
  int         pos [2];
  int         flen [2];
  logic [7:0] frame [2][7];
  logic [7:0] last_sent [2];
  bit         m_done [2];

  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  int         done_cnt [2];
  int         busy_cnt [2];

  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] got=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Frame-level model: consume one byte per accepted handshake, build a new frame on a read request.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        active[k] = 0; pos[k] = 0; last_sent[k] = 8'h00; m_done[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] = 0;
        if (active[k]) begin
          if (rdy[k]) begin
            last_sent[k] = frame[k][pos[k]];
            pos[k]++;
            if (pos[k] == flen[k]) begin
              active[k] = 0;
              m_done[k] = 1;
            end
          end
        end else if (start && rnotw) begin
          frame[k][0] = 8'hA5;
          frame[k][1] = init_re;
          frame[k][2] = init_im;
          frame[k][3] = re_coeff;
          frame[k][4] = im_coeff;
          frame[k][5] = power;
          frame[k][6] = init_re ^ init_im ^ re_coeff ^ im_coeff ^ power;
          flen[k] = (k == 0) ? 7 : 6;
          pos[k] = 0;
          active[k] = 1;
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle and log accepted bytes.
  always @(negedge clk) begin
    logic [7:0] exp_data;
    for (int k = 0; k < 2; k++) begin
      exp_data = active[k] ? frame[k][pos[k]] : last_sent[k];
      check("out_valid", k, {31'd0, d_valid[k]}, {31'd0, active[k]});
      check("busy", k, {31'd0, d_busy[k]}, {31'd0, active[k]});
      check("out_last", k, {31'd0, d_last[k]}, {31'd0, active[k] && (pos[k] == flen[k] - 1)});
      check("out_data", k, {24'd0, d_data[k]}, {24'd0, exp_data});
      check("done", k, {31'd0, d_done[k]}, {31'd0, m_done[k]});
      if (d_valid[k] && rdy[k]) begin
        if (k == 0) cap0.push_back(d_data[k]);
        else cap1.push_back(d_data[k]);
      end
      if (d_done[k]) done_cnt[k]++;
      if (d_busy[k]) busy_cnt[k]++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    cap0.delete();
    cap1.delete();
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      busy_cnt[k] = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy0 || busy1) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s timeout busy0=%0b busy1=%0b expected idle", name, busy0, busy1);
    end
    tick(2);
  endtask

  function automatic logic [7:0] get_cap(input int k, input int i);
    if (k == 0) return cap0[i];
    return cap1[i];
  endfunction

  function automatic int cap_size(input int k);
    if (k == 0) return cap0.size();
    return cap1.size();
  endfunction

  task automatic check_frame(input string name, input int k, input int len, input logic [7:0] e [7]);
    check({name, "_len"}, k, cap_size(k), len);
    for (int i = 0; i < len; i++)
      if (i < cap_size(k)) check({name, "_byte"}, k, {24'd0, get_cap(k, i)}, {24'd0, e[i]});
  endtask

  logic [7:0] ref7 [7];

  initial begin
    ref7 = '{8'hA5, 8'h20, 8'h00, 8'h7D, 8'h1B, 8'h10, 8'h56};
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    tick(2);
    for (int k = 0; k < 2; k++) begin
      check("rst_out_data", k, {24'd0, d_data[k]}, 32'h0);
      check("rst_out_valid", k, {31'd0, d_valid[k]}, 32'h0);
      check("rst_busy", k, {31'd0, d_busy[k]}, 32'h0);
    end
    reset_n = 1'b1;
    tick(2);

    // Basic frame with the reference register values.
    init_re = 8'h20; init_im = 8'h00; re_coeff = 8'h7D; im_coeff = 8'h1B; power = 8'h10;
    rnotw = 1'b1;
    clear_logs();
    pulse_start();
    wait_idle("basic");
    check("model_checksum", 0, {24'd0, frame[0][6]}, 32'h56);
    check_frame("basic", 0, 7, ref7);
    check_frame("basic", 1, 6, ref7);
    check("basic_done_cnt", 0, done_cnt[0], 1);
    check("basic_done_cnt", 1, done_cnt[1], 1);
    check("basic_busy_cycles", 0, busy_cnt[0], 7);
    check("basic_busy_cycles", 1, busy_cnt[1], 6);

    // Random backpressure on both sinks.
    clear_logs();
    pulse_start();
    for (int n = 0; n < 200 && (busy0 || busy1); n++) begin
      rdy[0] = 1'($urandom_range(0, 1));
      rdy[1] = 1'($urandom_range(0, 1));
      tick();
    end
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    wait_idle("backpressure");
    check_frame("backpressure", 0, 7, ref7);
    check_frame("backpressure", 1, 6, ref7);

    // Inputs and read mode change mid-frame; the snapshot must win.
    clear_logs();
    pulse_start();
    tick(2);
    power = 8'hFF;
    rnotw = 1'b0;
    wait_idle("snapshot");
    check_frame("snapshot", 0, 7, ref7);
    check_frame("snapshot", 1, 6, ref7);
    check("snapshot_done_cnt", 0, done_cnt[0], 1);
    power = 8'h10;

    // Request while in write mode is ignored.
    clear_logs();
    start = 1'b1;
    tick(3);
    start = 1'b0;
    check("gate_busy", 0, {31'd0, busy0}, 32'h0);
    check("gate_valid", 1, {31'd0, bus1.out_valid}, 32'h0);
    check("gate_done_cnt", 0, done_cnt[0], 0);

    // Held start: ignored during SEND, honoured on the done cycle.
    rnotw = 1'b1;
    clear_logs();
    start = 1'b1;
    tick(9);
    start = 1'b0;
    wait_idle("held_start");
    check("held_done_cnt", 0, done_cnt[0], 2);
    check("held_done_cnt", 1, done_cnt[1], 2);
    check("held_bytes", 0, cap0.size(), 14);
    check("held_bytes", 1, cap1.size(), 12);

    // Asynchronous reset in the middle of a frame.
    clear_logs();
    pulse_start();
    tick(3);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_valid", k, {31'd0, d_valid[k]}, 32'h0);
      check("arst_busy", k, {31'd0, d_busy[k]}, 32'h0);
      check("arst_last", k, {31'd0, d_last[k]}, 32'h0);
    end
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("arst_done_cnt", 0, done_cnt[0], 0);
    check("arst_done_cnt", 1, done_cnt[1], 0);
    clear_logs();
    pulse_start();
    wait_idle("after_reset");
    check_frame("after_reset", 0, 7, ref7);
    check_frame("after_reset", 1, 6, ref7);

    // Fully random traffic checked only by the model.
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 3) == 0);
      rnotw = ($urandom_range(0, 3) != 0);
      rdy[0] = 1'($urandom_range(0, 1));
      rdy[1] = 1'($urandom_range(0, 1));
      init_re = 8'($urandom);
      init_im = 8'($urandom);
      re_coeff = 8'($urandom);
      im_coeff = 8'($urandom);
      power = 8'($urandom);
      tick();
    end
    start = 1'b0;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
